mem_bus_bridge: RTL and testbench

Multi-cycle adapter between the MEM stage's single-cycle RAM control outputs and a handshaked data bus (`bus_req`/`bus_ack`) to slower memory. It latches each access the MEM stage issues and drives it onto the bus until the bus acknowledges it. It holds the pipeline with `stall_req` while the access is outstanding and returns registered read data toward WB. A timeout counter terminates hung transactions with an error pulse.

---
 rtl/mem_bus_bridge.sv | 95 +++++++++
 tb/tb_mem_bus_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: holds one MEM-stage RAM access on a req/ack bus
// until it is acknowledged or times out, stalling the pipeline meanwhile.
module mem_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_en,
   input  logic [3:0]  ram_write_en,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_write_data,
   output logic [31:0] ram_read_data,
   output logic        stall_req,
   output logic        bus_req,
   output logic [3:0]  bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   // 9-bit compare so the saturating 8-bit count never aliases the limit
   localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);

   state_t     state;
   logic [7:0] cnt;
   logic [8:0] cnt_inc;
   logic       to_hit;

   assign cnt_inc = {1'b0, cnt} + 9'd1;
   assign to_hit  = (TO_LIM != 9'd0) && (cnt_inc == TO_LIM);

   // Hold the pipeline from the issuing cycle until the access completes
   assign stall_req = ((state == IDLE) && ram_en) || (state == REQ);

   // Access FSM with registered bus outputs, read capture and error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         bus_req       <= 1'b0;
         bus_we        <= 4'd0;
         bus_addr      <= 32'd0;
         bus_wdata     <= 32'd0;
         ram_read_data <= 32'd0;
         bus_err       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ram_en) begin
                  bus_addr  <= ram_addr;
                  bus_we    <= ram_write_en;
                  bus_wdata <= ram_write_data;
                  bus_req   <= 1'b1;
                  cnt       <= 8'd0;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (bus_we == 4'd0) begin
                     ram_read_data <= bus_rdata;
                  end
                  state <= DONE;
               end else if (to_hit) begin
                  bus_req <= 1'b0;
                  if (bus_we == 4'd0) begin
                     ram_read_data <= 32'd0;
                  end
                  bus_err <= 1'b1;
                  state   <= DONE;
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               bus_err <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: scoreboard bench driving three bridges with
// different timeouts from shared inputs, checking one at a time.
module tb_mem_bus_bridge;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          reqs;
   } exp_t;

   localparam int TO0 = 255;
   localparam int TO1 = 4;
   localparam int TO2 = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ram_en;
   logic [3:0]  ram_write_en;
   logic [31:0] ram_addr;
   logic [31:0] ram_write_data;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   logic [31:0] o_rd    [3];
   logic        o_stall [3];
   logic        o_req   [3];
   logic [3:0]  o_we    [3];
   logic [31:0] o_addr  [3];
   logic [31:0] o_wdata [3];
   logic        o_err   [3];

   int          to_of   [3];
   logic [31:0] last_rd [3];
   exp_t        sbq[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          cyc    = 0;
   int          s1, s2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_bus_bridge #(.TIMEOUT_CYCLES(TO0)) u_t255 (
      .clk(clk), .rst(rst), .ram_en(ram_en),
      .ram_write_en(ram_write_en), .ram_addr(ram_addr),
      .ram_write_data(ram_write_data), .ram_read_data(o_rd[0]),
      .stall_req(o_stall[0]), .bus_req(o_req[0]), .bus_we(o_we[0]),
      .bus_addr(o_addr[0]), .bus_wdata(o_wdata[0]), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata), .bus_err(o_err[0])
   );

   mem_bus_bridge #(.TIMEOUT_CYCLES(TO1)) u_t4 (
      .clk(clk), .rst(rst), .ram_en(ram_en),
      .ram_write_en(ram_write_en), .ram_addr(ram_addr),
      .ram_write_data(ram_write_data), .ram_read_data(o_rd[1]),
      .stall_req(o_stall[1]), .bus_req(o_req[1]), .bus_we(o_we[1]),
      .bus_addr(o_addr[1]), .bus_wdata(o_wdata[1]), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata), .bus_err(o_err[1])
   );

   mem_bus_bridge #(.TIMEOUT_CYCLES(TO2)) u_t2 (
      .clk(clk), .rst(rst), .ram_en(ram_en),
      .ram_write_en(ram_write_en), .ram_addr(ram_addr),
      .ram_write_data(ram_write_data), .ram_read_data(o_rd[2]),
      .stall_req(o_stall[2]), .bus_req(o_req[2]), .bus_we(o_we[2]),
      .bus_addr(o_addr[2]), .bus_wdata(o_wdata[2]), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata), .bus_err(o_err[2])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      ram_en = 1'b0;
      bus_ack = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
   endtask

   // One access checked on instance i; ack_at = REQ cycle of ack, 0 = none
   task automatic access(input int i, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rdat,
                         output int start);
      exp_t e, g;
      int   k, stalls;
      e.err  = (to_of[i] != 0) && (ack_at == 0 || ack_at > to_of[i]);
      e.reqs = e.err ? to_of[i] : ack_at;
      e.rd   = (we != 4'd0) ? last_rd[i] : (e.err ? 32'd0 : rdat);
      sbq.push_back(e);
      last_rd[i] = e.rd;
      ram_en = 1'b1;
      ram_write_en = we;
      ram_addr = addr;
      ram_write_data = wd;
      @(negedge clk);
      chk("stall_issue", 32'(o_stall[i]), 32'd1);
      stalls = 1;
      @(posedge clk); #1;
      start = cyc;
      ram_en = 1'b0;
      ram_addr = ~addr;
      ram_write_en = ~we;
      ram_write_data = ~wd;
      k = 0;
      while (o_req[i] && k < 300) begin
         k++;
         bus_ack = (k == ack_at);
         bus_rdata = (k == ack_at) ? rdat : $urandom;
         @(negedge clk);
         chk("bus_addr", o_addr[i], addr);
         chk("bus_we", 32'(o_we[i]), 32'(we));
         chk("bus_wdata", o_wdata[i], wd);
         if (o_stall[i]) stalls++;
         @(posedge clk); #1;
         bus_ack = 1'b0;
      end
      g = sbq.pop_front();
      @(negedge clk);
      chk("req_cycles", k, g.reqs);
      chk("stall_cycles", stalls, g.reqs + 1);
      chk("stall_done", 32'(o_stall[i]), 32'd0);
      chk("rdata", o_rd[i], g.rd);
      chk("err_done", 32'(o_err[i]), 32'(g.err));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      to_of[0] = TO0;
      to_of[1] = TO1;
      to_of[2] = TO2;
      ram_write_en = 4'd0;
      ram_addr = 32'd0;
      ram_write_data = 32'd0;
      bus_rdata = 32'd0;
      do_reset();
      do_reset();
      @(negedge clk);
      chk("rst_req", 32'(o_req[0]), 32'd0);
      chk("rst_stall", 32'(o_stall[0]), 32'd0);
      chk("rst_addr", o_addr[0], 32'd0);
      chk("rst_rd", o_rd[0], 32'd0);
      chk("rst_err", 32'(o_err[0]), 32'd0);
      @(posedge clk); #1;

      // reset in the middle of a request
      ram_en = 1'b1;
      ram_write_en = 4'd0;
      ram_addr = 32'h100;
      ram_write_data = 32'h77;
      @(posedge clk); #1;
      ram_en = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_req", 32'(o_req[0]), 32'd1);
      chk("mid_addr", o_addr[0], 32'h100);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_req", 32'(o_req[0]), 32'd0);
      chk("abort_stall", 32'(o_stall[0]), 32'd0);
      chk("abort_addr", o_addr[0], 32'd0);
      chk("abort_wdata", o_wdata[0], 32'd0);
      chk("abort_we", 32'(o_we[0]), 32'd0);
      chk("abort_err", 32'(o_err[0]), 32'd0);
      rst = 1'b0;
      do_reset();

      // zero-wait read, then wait-state write that must keep the data
      access(0, 4'd0, 32'h0000_1004, 32'd0, 1, 32'hDEAD_BEEF, s1);
      do_reset();
      access(0, 4'd0, 32'h0000_1004, 32'd0, 1, 32'hDEAD_BEEF, s1);
      access(0, 4'b1100, 32'h0000_2000, 32'hABCD_0000, 5, 32'h1234_5678, s1);

      // back-to-back reads
      do_reset();
      access(0, 4'd0, 32'h10, 32'd0, 1, 32'h11, s1);
      access(0, 4'd0, 32'h14, 32'd0, 1, 32'h22, s2);
      chk("b2b_gap", s2 - s1, 3);

      // timeout on a read after a successful one, then a stray ack
      do_reset();
      access(1, 4'd0, 32'h40, 32'd0, 1, 32'hCAFE_F00D, s1);
      access(1, 4'd0, 32'h44, 32'd0, 0, 32'd0, s1);
      @(negedge clk);
      chk("err_one_cycle", 32'(o_err[1]), 32'd0);
      bus_ack = 1'b1;
      bus_rdata = 32'h9999_9999;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("stray_req", 32'(o_req[1]), 32'd0);
      chk("stray_rd", o_rd[1], 32'd0);
      chk("stray_err", 32'(o_err[1]), 32'd0);
      @(posedge clk); #1;

      // ack arriving in the timeout cycle wins
      do_reset();
      access(2, 4'd0, 32'h80, 32'd0, 2, 32'h5A5A_5A5A, s1);
      access(1, 4'd0, 32'h84, 32'd0, 4, 32'hA5A5_0001, s1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
